fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 137 +++++++++++++
 tb/tb_fetch_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives a single-outstanding-request instruction memory
// and fills the IF/ID pipeline register, handling stalls, wait states and redirects.
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        PCWrite,
    input  logic        IFID_Write,
    input  logic        Branch_Taken,
    input  logic [63:0] Branch_Target,
    input  logic        IMem_Ready,
    input  logic [31:0] IMem_RData,
    output logic        IMem_Req,
    output logic [63:0] IMem_Addr,
    output logic [63:0] IFID_PC,
    output logic [31:0] IFID_Instruction,
    output logic        IFID_Valid
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        SQUASH = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] ifidPc_q, ifidPc_d;
    logic [31:0] ifidInstr_q, ifidInstr_d;
    logic [31:0] holdBuf_q, holdBuf_d;
    logic        ifidValid_q, ifidValid_d;

    logic        advance;
    logic [63:0] target;

    assign advance = PCWrite & IFID_Write;
    assign target  = {Branch_Target[63:2], 2'b00};

    // In SQUASH, pc_q holds the pending redirect while addr_q keeps the abandoned request.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        ifidPc_d    = ifidPc_q;
        ifidInstr_d = ifidInstr_q;
        holdBuf_d   = holdBuf_q;
        ifidValid_d = ifidValid_q;

        case (state_q)
            FETCH: begin
                if (Branch_Taken) begin
                    pc_d        = target;
                    ifidValid_d = 1'b0;
                    if (IMem_Ready) begin
                        addr_d = target;
                    end else begin
                        state_d = SQUASH;
                    end
                end else if (IMem_Ready) begin
                    if (advance) begin
                        ifidPc_d    = addr_q;
                        ifidInstr_d = IMem_RData;
                        ifidValid_d = 1'b1;
                        pc_d        = addr_q + 64'd4;
                        addr_d      = addr_q + 64'd4;
                    end else begin
                        holdBuf_d = IMem_RData;
                        state_d   = HOLD;
                    end
                end else if (IFID_Write) begin
                    ifidValid_d = 1'b0;
                end
            end

            HOLD: begin
                if (Branch_Taken) begin
                    pc_d        = target;
                    addr_d      = target;
                    ifidValid_d = 1'b0;
                    state_d     = FETCH;
                end else if (advance) begin
                    ifidPc_d    = pc_q;
                    ifidInstr_d = holdBuf_q;
                    ifidValid_d = 1'b1;
                    pc_d        = pc_q + 64'd4;
                    addr_d      = pc_q + 64'd4;
                    state_d     = FETCH;
                end
            end

            SQUASH: begin
                ifidValid_d = 1'b0;
                if (Branch_Taken) begin
                    pc_d = target;
                end
                if (IMem_Ready) begin
                    addr_d  = Branch_Taken ? target : pc_q;
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            addr_q      <= RESET_PC;
            ifidPc_q    <= 64'h0;
            ifidInstr_q <= 32'h0;
            holdBuf_q   <= 32'h0;
            ifidValid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            ifidPc_q    <= ifidPc_d;
            ifidInstr_q <= ifidInstr_d;
            holdBuf_q   <= holdBuf_d;
            ifidValid_q <= ifidValid_d;
        end
    end

    // Gated by RESET so the request drops the moment reset asserts, not at the next edge.
    assign IMem_Req         = ~RESET & (state_q != HOLD);
    assign IMem_Addr        = addr_q;
    assign IFID_PC          = ifidPc_q;
    assign IFID_Instruction = ifidInstr_q;
    assign IFID_Valid       = ifidValid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a per-cycle vector table with a scoreboard queue,
// plus hand-written reset sequences around an abandoned request.
module tb_fetch_unit;

    typedef struct packed {
        logic        req;
        logic [63:0] addr;
        logic [63:0] ifidPc;
        logic [31:0] instr;
        logic        valid;
    } outs_t;

    typedef struct packed {
        logic        ready;
        logic        pcw;
        logic        ifw;
        logic        br;
        logic [63:0] tgt;
        outs_t       exp;
    } vec_t;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b0;
    logic        PCWrite = 1'b0;
    logic        IFID_Write = 1'b0;
    logic        Branch_Taken = 1'b0;
    logic [63:0] Branch_Target = 64'h0;
    logic        IMem_Ready = 1'b0;
    logic [31:0] IMem_RData = 32'h0;
    logic        IMem_Req;
    logic [63:0] IMem_Addr;
    logic [63:0] IFID_PC;
    logic [31:0] IFID_Instruction;
    logic        IFID_Valid;

    int    testsRun = 0;
    int    testsFailed = 0;
    outs_t expQ[$];
    vec_t  vecs[$];

    fetch_unit #(.RESET_PC(64'h0)) dut (
        .CLOCK           (CLOCK),
        .RESET           (RESET),
        .PCWrite         (PCWrite),
        .IFID_Write      (IFID_Write),
        .Branch_Taken    (Branch_Taken),
        .Branch_Target   (Branch_Target),
        .IMem_Ready      (IMem_Ready),
        .IMem_RData      (IMem_RData),
        .IMem_Req        (IMem_Req),
        .IMem_Addr       (IMem_Addr),
        .IFID_PC         (IFID_PC),
        .IFID_Instruction(IFID_Instruction),
        .IFID_Valid      (IFID_Valid)
    );

    always #5 CLOCK = ~CLOCK;

    function automatic vec_t mk(input logic rdy, input logic pcw, input logic ifw,
                                input logic br, input logic [63:0] tgt,
                                input logic req, input logic [63:0] addr,
                                input logic [63:0] ipc, input logic [31:0] ins,
                                input logic vld);
        vec_t v;
        v.ready = rdy;
        v.pcw = pcw;
        v.ifw = ifw;
        v.br = br;
        v.tgt = tgt;
        v.exp.req = req;
        v.exp.addr = addr;
        v.exp.ifidPc = ipc;
        v.exp.instr = ins;
        v.exp.valid = vld;
        return v;
    endfunction

    function automatic outs_t mkOut(input logic req, input logic [63:0] addr,
                                    input logic [63:0] ipc, input logic [31:0] ins,
                                    input logic vld);
        outs_t o;
        o.req = req;
        o.addr = addr;
        o.ifidPc = ipc;
        o.instr = ins;
        o.valid = vld;
        return o;
    endfunction

    task automatic checkOutput(input string name, input outs_t e);
        testsRun++;
        if (IMem_Req !== e.req || IMem_Addr !== e.addr || IFID_PC !== e.ifidPc ||
            IFID_Instruction !== e.instr || IFID_Valid !== e.valid) begin
            testsFailed++;
            $display("[TB] FAIL %s: got req=%0b addr=%h pc=%h instr=%h valid=%0b, expected req=%0b addr=%h pc=%h instr=%h valid=%0b",
                     name, IMem_Req, IMem_Addr, IFID_PC, IFID_Instruction, IFID_Valid,
                     e.req, e.addr, e.ifidPc, e.instr, e.valid);
        end
    endtask

    // The bench acts as the memory: returned word is 0xA000_0000 plus the requested address.
    task automatic applyStimulus(input vec_t v);
        IMem_Ready    = v.ready;
        IMem_RData    = 32'hA000_0000 + IMem_Addr[31:0];
        PCWrite       = v.pcw;
        IFID_Write    = v.ifw;
        Branch_Taken  = v.br;
        Branch_Target = v.tgt;
        expQ.push_back(v.exp);
        @(posedge CLOCK);
        #1;
    endtask

    initial begin
        outs_t e;

        // rdy pcw ifw br target | req addr ifidPc instr valid
        vecs.push_back(mk(1,1,1,0,64'h0,    1,64'h4,  64'h0,  32'hA000_0000,1));
        vecs.push_back(mk(1,1,1,0,64'h0,    1,64'h8,  64'h4,  32'hA000_0004,1));
        vecs.push_back(mk(1,0,0,0,64'h0,    0,64'h8,  64'h4,  32'hA000_0004,1));
        vecs.push_back(mk(1,0,0,0,64'h0,    0,64'h8,  64'h4,  32'hA000_0004,1));
        vecs.push_back(mk(0,1,1,0,64'h0,    1,64'hC,  64'h8,  32'hA000_0008,1));
        vecs.push_back(mk(0,1,1,0,64'h0,    1,64'hC,  64'h8,  32'hA000_0008,0));
        vecs.push_back(mk(0,1,1,0,64'h0,    1,64'hC,  64'h8,  32'hA000_0008,0));
        vecs.push_back(mk(0,1,1,0,64'h0,    1,64'hC,  64'h8,  32'hA000_0008,0));
        vecs.push_back(mk(1,1,1,0,64'h0,    1,64'h10, 64'hC,  32'hA000_000C,1));
        vecs.push_back(mk(0,1,1,1,64'h103,  1,64'h10, 64'hC,  32'hA000_000C,0));
        vecs.push_back(mk(0,1,1,0,64'h0,    1,64'h10, 64'hC,  32'hA000_000C,0));
        vecs.push_back(mk(1,1,1,0,64'h0,    1,64'h100,64'hC,  32'hA000_000C,0));
        vecs.push_back(mk(1,1,1,0,64'h0,    1,64'h104,64'h100,32'hA000_0100,1));
        vecs.push_back(mk(0,1,1,1,64'h200,  1,64'h104,64'h100,32'hA000_0100,0));
        vecs.push_back(mk(0,1,1,1,64'h302,  1,64'h104,64'h100,32'hA000_0100,0));
        vecs.push_back(mk(1,1,1,0,64'h0,    1,64'h300,64'h100,32'hA000_0100,0));
        vecs.push_back(mk(1,1,1,0,64'h0,    1,64'h304,64'h300,32'hA000_0300,1));
        vecs.push_back(mk(0,1,0,0,64'h0,    1,64'h304,64'h300,32'hA000_0300,1));
        vecs.push_back(mk(1,1,1,1,64'h500,  1,64'h500,64'h300,32'hA000_0300,0));
        vecs.push_back(mk(1,1,1,0,64'h0,    1,64'h504,64'h500,32'hA000_0500,1));
        vecs.push_back(mk(1,0,0,0,64'h0,    0,64'h504,64'h500,32'hA000_0500,1));
        vecs.push_back(mk(0,0,0,1,64'h600,  1,64'h600,64'h500,32'hA000_0500,0));
        vecs.push_back(mk(1,1,1,0,64'h0,    1,64'h604,64'h600,32'hA000_0600,1));
        vecs.push_back(mk(1,1,1,1,64'hFFFF_FFFF_FFFF_FFFC, 1,64'hFFFF_FFFF_FFFF_FFFC,64'h600,32'hA000_0600,0));
        vecs.push_back(mk(1,1,1,0,64'h0,    1,64'h0,  64'hFFFF_FFFF_FFFF_FFFC,32'h9FFF_FFFC,1));
        vecs.push_back(mk(1,1,1,0,64'h0,    1,64'h4,  64'h0,  32'hA000_0000,1));
        vecs.push_back(mk(0,0,0,1,64'h40,   1,64'h4,  64'h0,  32'hA000_0000,0));
        vecs.push_back(mk(1,1,1,0,64'h0,    1,64'h40, 64'h0,  32'hA000_0000,0));
        vecs.push_back(mk(0,1,1,1,64'h80,   1,64'h40, 64'h0,  32'hA000_0000,0));

        // Reset is asynchronous, so its values must appear without any clock edge.
        #1 RESET = 1'b1;
        #1 checkOutput("resetAsync", mkOut(0, 64'h0, 64'h0, 32'h0, 0));

        IMem_Ready = 1'b1;
        IMem_RData = 32'hDEAD_BEEF;
        PCWrite    = 1'b1;
        IFID_Write = 1'b1;
        @(posedge CLOCK);
        #1 checkOutput("resetHeldOverEdge", mkOut(0, 64'h0, 64'h0, 32'h0, 0));

        #1 RESET = 1'b0;
        #1 checkOutput("reqAfterRelease", mkOut(1, 64'h0, 64'h0, 32'h0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            if (expQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL scoreboardEmpty%0d: got empty queue, expected an entry", i);
            end else begin
                e = expQ.pop_front();
                checkOutput($sformatf("vec%0d", i), e);
            end
        end

        // DUT is now in SQUASH with a request to 0x40 outstanding; reset between edges.
        Branch_Taken = 1'b0;
        IMem_Ready   = 1'b0;
        #2 RESET = 1'b1;
        #1 checkOutput("resetInSquash", mkOut(0, 64'h0, 64'h0, 32'h0, 0));
        IMem_Ready = 1'b1;
        IMem_RData = 32'h1234_5678;
        #1 RESET = 1'b0;
        #1 checkOutput("squashReleased", mkOut(1, 64'h0, 64'h0, 32'h0, 0));

        applyStimulus(mk(1,1,1,0,64'h0, 1,64'h4, 64'h0, 32'hA000_0000,1));
        e = expQ.pop_front();
        checkOutput("firstFetchAfterReset", e);

        applyStimulus(mk(1,1,1,0,64'h0, 1,64'h8, 64'h4, 32'hA000_0004,1));
        e = expQ.pop_front();
        checkOutput("secondFetchAfterReset", e);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
